// File: rtl/alu_serial_frontend.sv
// Bit-serial command front end for the 8-bit ALU.
// Deserializes a 16-bit frame {opcode, operand1, operand2}, drives the ALU,
// waits SETTLE_CYCLES, then serializes the 8-bit result back MSB first.
module alu_serial_frontend #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  input  logic       ser_sof,
  output logic [3:0] alu_sel,
  output logic [3:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       ser_out,
  output logic       ser_out_valid,
  output logic       busy,
  output logic       err,
  output logic       ovr
);

  typedef enum logic [1:0] {RX, SETTLE, TX} state_t;

  localparam logic [3:0] SET_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nx;
  logic [14:0] rx_shift;   // first 15 bits of the frame in flight
  logic [3:0]  bit_cnt;    // bits accepted so far in this frame
  logic [3:0]  set_cnt;
  logic [2:0]  tx_cnt;
  logic [7:0]  tx_shift;

  logic take, frame_done, settle_done, tx_done, illegal;

  assign take        = ser_valid && (state == RX);
  assign frame_done  = take && !ser_sof && (bit_cnt == 4'd15);
  assign settle_done = (state == SETTLE) && (set_cnt == SET_LAST);
  assign tx_done     = (state == TX) && (tx_cnt == 3'd7);
  // Opcode is taken from the held ALU pins, which are stable until the next frame
  assign illegal     = (alu_sel >= 4'd13);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX;
    else        state <= state_nx;
  end

  // Next-state logic and status outputs decoded from the state
  always_comb begin
    state_nx      = state;
    busy          = (state != RX);
    ser_out_valid = (state == TX);
    ser_out       = (state == TX) && tx_shift[7];
    case (state)
      RX:      if (frame_done)  state_nx = SETTLE;
      SETTLE:  if (settle_done) state_nx = TX;
      TX:      if (tx_done)     state_nx = RX;
      default:                  state_nx = RX;
    endcase
  end

  // Receive path: shift register, bit counter and ALU operand latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else if (take) begin
      if (ser_sof) begin
        // SOF bit is always bit 15; anything collected before it is dropped
        rx_shift <= {14'd0, ser_in};
        bit_cnt  <= 4'd1;
      end else if (bit_cnt == 4'd15) begin
        {alu_sel, alu_a, alu_b} <= {rx_shift, ser_in};
        bit_cnt  <= '0;
      end else begin
        rx_shift <= {rx_shift[13:0], ser_in};
        bit_cnt  <= bit_cnt + 4'd1;
      end
    end
  end

  // Settle timer, result capture and transmit shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt  <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      err      <= 1'b0;
    end else if (frame_done) begin
      set_cnt <= '0;
    end else if (state == SETTLE) begin
      set_cnt <= set_cnt + 4'd1;
      if (settle_done) begin
        tx_shift <= illegal ? 8'h00 : alu_result;
        err      <= illegal;
        tx_cnt   <= '0;
      end
    end else if (state == TX) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
      tx_cnt   <= tx_cnt + 3'd1;
    end
  end

  // Sticky overrun: any bit offered while not receiving is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovr <= 1'b0;
    else if (ser_valid && state != RX) ovr <= 1'b1;
    else if (take && ser_sof)       ovr <= 1'b0;
  end

endmodule

// File: tb/tb_alu_serial_frontend.sv
// Directed + randomized bench for alu_serial_frontend with a frame-level model.
module tb_alu_serial_frontend;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0, ser_valid = 1'b0, ser_sof = 1'b0;
  logic [3:0] alu_sel, alu_a;
  logic [7:0] alu_b, alu_result;
  logic       ser_out, ser_out_valid, busy, err, ovr;

  int n_chk = 0;
  int n_bad = 0;
  logic ovr_exp = 1'b0;

  always #5 clk = ~clk;

  alu_serial_frontend #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_sof(ser_sof), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .busy(busy), .err(err), .ovr(ovr)
  );

  // Stand-in ALU (stimulus only); ADD and AND match the real ALU
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [7:0] b);
    case (op)
      4'd0:    return 8'(a) + b;
      4'd1:    return b - 8'(a);
      4'd4:    return 8'(a) & b;
      4'd5:    return 8'(a) | b;
      4'd6:    return 8'(a) ^ b;
      default: return {op, a} ^ b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_a, alu_b);

  // Expected serialized result for a frame
  function automatic logic [7:0] exp_res(input logic [15:0] f);
    return (f[15:12] >= 4'd13) ? 8'h00 : alu_f(f[15:12], f[11:8], f[7:0]);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Send a frame MSB first; gap[i] inserts 3 idle cycles after bit i
  task automatic send_frame(input logic [15:0] f, input logic sof, input logic [15:0] gap);
    logic [15:0] old_ops;
    old_ops = {alu_sel, alu_a, alu_b};
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) chk("ops_hold", {alu_sel, alu_a, alu_b}, old_ops);
      ser_in = f[i]; ser_valid = 1'b1; ser_sof = sof && (i == 15);
      tick();
      ser_valid = 1'b0; ser_sof = 1'b0;
      if (sof && i == 15) begin
        ovr_exp = 1'b0;
        chk("ovr_sof_clr", 16'(ovr), 16'(ovr_exp));
      end
      if (gap[i] && i != 0) repeat (3) tick();
    end
    chk("ops", {alu_sel, alu_a, alu_b}, f);
    chk("busy_rise", 16'(busy), 16'd1);
  endtask

  // Collect the result; optional overrun pulse at bit pulse_at; stop early after stop bits
  task automatic get_result(input logic [15:0] f, input int pulse_at, input int stop);
    int k;
    logic [7:0] r;
    r = exp_res(f);
    k = 0;
    while (!ser_out_valid && k < 40) begin
      chk("busy_settle", 16'(busy), 16'd1);
      tick(); k++;
    end
    chk("latency", 16'(k), 16'(S));
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == stop) return;
      chk("tx_valid", 16'(ser_out_valid), 16'd1);
      chk("tx_bit", 16'(ser_out), 16'(r[i]));
      chk("busy_tx", 16'(busy), 16'd1);
      if (i == 7) chk("err", 16'(err), 16'(f[15:12] >= 4'd13));
      if (7 - i == pulse_at) begin
        ser_valid = 1'b1; ser_in = 1'b1; ser_sof = $urandom_range(0, 1);
        ovr_exp = 1'b1;
      end
      tick();
      ser_valid = 1'b0; ser_sof = 1'b0;
    end
    chk("busy_fall", 16'(busy), 16'd0);
    chk("tx_done", 16'(ser_out_valid), 16'd0);
    chk("ovr", 16'(ovr), 16'(ovr_exp));
  endtask

  function automatic logic [15:0] outs();
    return {alu_sel, alu_a, alu_b} | 16'({ser_out, ser_out_valid, busy, err, ovr});
  endfunction

  initial begin
    logic [15:0] f, g;
    // Reset state
    #12;
    chk("reset_outs", outs(), 16'h0);
    chk("reset_flags", 16'({ser_out, ser_out_valid, busy, err, ovr}), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD back-to-back, no SOF needed after reset
    send_frame(16'h0F9E, 1'b0, 16'h0);
    get_result(16'h0F9E, -1, 8);

    // AND with gaps after bit 9 and bit 3
    send_frame(16'h4F9E, 1'b0, 16'h0208);
    get_result(16'h4F9E, -1, 8);

    // Illegal opcode then ADD clears err
    send_frame(16'hDF9E, 1'b0, 16'h0);
    get_result(16'hDF9E, -1, 8);
    send_frame(16'h0F9E, 1'b0, 16'h0);
    get_result(16'h0F9E, -1, 8);

    // Resync: 7 garbage bits then a SOF frame
    for (int i = 0; i < 7; i++) begin
      ser_in = $urandom_range(0, 1); ser_valid = 1'b1; tick();
    end
    ser_valid = 1'b0;
    send_frame(16'h0F9E, 1'b1, 16'h0);
    get_result(16'h0F9E, -1, 8);

    // Overrun during TX, then SOF clears it
    send_frame(16'h0F9E, 1'b1, 16'h0);
    get_result(16'h0F9E, 4, 8);
    send_frame(16'h4F9E, 1'b1, 16'h0);
    get_result(16'h4F9E, -1, 8);

    // Reset during TX after 3 result bits
    send_frame(16'h0F9E, 1'b1, 16'h0);
    get_result(16'h0F9E, -1, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 16'h0);
    chk("async_reset_flags", 16'({ser_out, ser_out_valid, busy, err, ovr}), 16'h0);
    ovr_exp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'h0F9E, 1'b0, 16'h0);
    get_result(16'h0F9E, -1, 8);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      f = 16'($urandom);
      g = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      send_frame(f, 1'($urandom_range(0, 1)), g);
      get_result(f, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
